frame_buf_arbiter: RTL and testbench
====================================

Name: frame_buf_arbiter

Overview:
Schedules SDRAM burst traffic between the camera write FIFO and the LCD read FIFO of the video capture system. It watches both FIFO fill levels and issues fixed-length write or read burst requests to the SDRAM controller through a req/ack/done handshake. It generates the burst addresses and manages triple-buffered frame banks, so the LCD never scans a bank that the camera is writing.

Parameters:
BURST_LEN, 8, words per SDRAM burst; power of two.
FRAME_WORDS, 76800, words per frame (320x240 RGB565); multiple of BURST_LEN.
ADDR_W, 22, SDRAM word address width; top 2 bits are the bank, the rest is the offset.
UW, 9, width of the FIFO used-word inputs.
RD_TH, 256, read FIFO refill threshold.
RD_URG, 64, read FIFO urgency threshold.

Ports:
clk  in  1  system clock
rst_n  in  1  reset
wrfifo_usedw  in  UW  camera write FIFO fill level
rdfifo_usedw  in  UW  LCD read FIFO fill level
cam_frame_start  in  1  one-clk pulse at camera frame start (clk domain)
rdfifo_clr  in  1  LCD frame-start level, high during LCD line 0
sd_req  out  1  burst request
sd_wr  out  1  1 = write burst, 0 = read burst; valid with sd_req
sd_addr  out  ADDR_W  burst start address {bank, offset}
sd_ack  in  1  controller accepted request
sd_done  in  1  one-clk pulse at burst completion
frame_ready  out  1  at least one complete frame stored
wr_overrun  out  1  sticky flag: camera data exceeded FRAME_WORDS in the current frame

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk. All registers go to reset values.
  - Output reset values: sd_req=0, sd_wr=0, sd_addr=0, frame_ready=0, wr_overrun=0.
  - Internal reset values: wr_bank=0, rd_bank=2, full_bank=2, wr_off=0, rd_off=0, last_wr=0, FSM=IDLE.
  - Reset mid-burst abandons the burst; the SDRAM controller shares the same reset.
- Need terms, evaluated in IDLE:
  - wr_need = wrfifo_usedw>=BURST_LEN && wr_off<FRAME_WORDS.
  - rd_need = frame_ready && !rdfifo_clr && rdfifo_usedw<=RD_TH && rd_off<FRAME_WORDS.
- Arbitration, evaluated in IDLE:
  - If rd_need and rdfifo_usedw<RD_URG: read.
  - Else if both needs are set: alternate, taking read if last_wr=1 and write otherwise.
  - Else: serve whichever need is set.
  - The grant updates last_wr.
- FSM states: IDLE, REQ, BUSY.
  - IDLE -> REQ on a grant. sd_req rises on the cycle after the need is sampled. sd_wr and sd_addr are registered at the same time.
  - REQ: sd_req, sd_wr and sd_addr are held stable until sd_ack=1. Then sd_req=0 next cycle and the FSM goes to BUSY.
  - REQ: if sd_ack and sd_done are both high in the same cycle, go straight to IDLE as burst complete.
  - BUSY: on sd_done, the served offset += BURST_LEN and the FSM returns to IDLE.
  - There is at least one IDLE cycle between bursts.
  - sd_done outside BUSY/REQ is ignored.
- Address: sd_addr = {bank[1:0], offset[ADDR_W-3:0]}, using wr_bank/wr_off for writes and rd_bank/rd_off for reads.
- Camera frame start: handling is deferred until the FSM is IDLE if a write burst is in flight; the pending flag is held. Then:
  - If wr_off==FRAME_WORDS: full_bank<=wr_bank, frame_ready<=1, and wr_bank<=the unique bank in {0,1,2} that is neither wr_bank nor rd_bank.
  - Otherwise the partial frame is discarded and wr_bank is unchanged.
  - In both cases wr_off<=0 and wr_overrun<=0.
- Overrun: when wr_off==FRAME_WORDS and wrfifo_usedw>=BURST_LEN, set wr_overrun=1. No write is issued.
- LCD frame start: on the rising edge of rdfifo_clr, rd_off<=0 and rd_bank<=full_bank. The update is deferred until IDLE if a read burst is in flight. Reads are suppressed while rdfifo_clr=1.
- Invariant: wr_bank != rd_bank at all times.
- Simultaneous camera frame start and rdfifo_clr edge: the camera update is applied first, so the reader takes the newly completed bank the same cycle.

Decomposition:
- Package vidsys_pkg holds:
  - bank type (2-bit) and constants BANK0..BANK2.
  - FSM state enum.
  - Default frame constants (H=320, V=240, FRAME_WORDS).
- One sub-module, fb_bank_sel: combinational selection of the free bank from (wr_bank, rd_bank) plus the full_bank register.
- Arbiter FSM and address counters stay in the top module.

Test Plan:
All scenarios use FRAME_WORDS=32 and BURST_LEN=8.
1. After reset, wrfifo_usedw=8 and rdfifo_usedw=0 -> one write request with sd_wr=1, sd_addr={0,0}. On ack then done, the next request is at offset 8. No read requests while frame_ready=0.
2. Write 4 bursts, then pulse cam_frame_start -> frame_ready=1, full_bank=0, wr_bank=1. Then a rdfifo_clr edge -> rd_bank=0 and the next read address is {0,0}.
3. Both needs set with rdfifo_usedw=100 -> grants alternate W,R,W,R. With rdfifo_usedw=10 (urgent) -> read wins every time.
4. wr_off=32 and wrfifo_usedw=8 -> no sd_req, wr_overrun=1. Next cam_frame_start clears the flag and switches to bank 2 (rd_bank=0).
5. Partial frame (16 words) then cam_frame_start -> wr_bank unchanged and wr_off=0. cam_frame_start arriving during BUSY is applied only after sd_done.
6. sd_ack and sd_done high in the same REQ cycle -> offset advances by 8 and the FSM returns to IDLE. Assert rst_n=0 during BUSY -> all outputs take reset values immediately.

Source files
------------

// File: rtl/vidsys_pkg.sv
// vidsys_pkg: shared video-system types (frame bank ids, arbiter FSM state, default frame geometry)
package vidsys_pkg;
  typedef logic [1:0] bank_t;
  localparam bank_t BANK0 = 2'd0;
  localparam bank_t BANK1 = 2'd1;
  localparam bank_t BANK2 = 2'd2;
  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;
  localparam int H_ACT = 320;
  localparam int V_ACT = 240;
  localparam int FRAME_WORDS_DEF = H_ACT * V_ACT;
endpackage

// File: rtl/fb_bank_sel.sv
// fb_bank_sel: picks the free bank of the triple buffer and holds the last completed (full) bank
//   in:  clk, rst_n, wr_bank, rd_bank, load (latch wr_bank as the new full bank)
//   out: free_bank (bank in {0,1,2} that is neither wr_bank nor rd_bank), full_sel (full bank incl. this cycle's load)
module fb_bank_sel
  import vidsys_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  bank_t wr_bank,
  input  bank_t rd_bank,
  input  logic  load,
  output bank_t free_bank,
  output bank_t full_sel
);
  bank_t full_bank;
  assign free_bank = (wr_bank != BANK0 && rd_bank != BANK0) ? BANK0 :
                     (wr_bank != BANK1 && rd_bank != BANK1) ? BANK1 : BANK2;
  // bypass lets a reader switching in the same cycle pick up the frame just completed
  assign full_sel = load ? wr_bank : full_bank;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) full_bank <= BANK2;
    else        full_bank <= full_sel;
endmodule

// File: rtl/frame_buf_arbiter.sv
// frame_buf_arbiter: schedules camera write / LCD read SDRAM bursts over a triple-buffered frame store
//   in:  clk, rst_n, wrfifo_usedw, rdfifo_usedw, cam_frame_start, rdfifo_clr, sd_ack, sd_done
//   out: sd_req/sd_wr/sd_addr (burst request, held until sd_ack), frame_ready, wr_overrun
module frame_buf_arbiter
  import vidsys_pkg::*;
#(
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int ADDR_W      = 22,
  parameter int UW          = 9,
  parameter int RD_TH       = 256,
  parameter int RD_URG      = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [UW-1:0]     wrfifo_usedw,
  input  logic [UW-1:0]     rdfifo_usedw,
  input  logic              cam_frame_start,
  input  logic              rdfifo_clr,
  output logic              sd_req,
  output logic              sd_wr,
  output logic [ADDR_W-1:0] sd_addr,
  input  logic              sd_ack,
  input  logic              sd_done,
  output logic              frame_ready,
  output logic              wr_overrun
);
  localparam int OW = ADDR_W - 2;
  localparam logic [OW-1:0] FW_O  = OW'(FRAME_WORDS);
  localparam logic [OW-1:0] BL_O  = OW'(BURST_LEN);
  localparam logic [UW-1:0] BL_U  = UW'(BURST_LEN);
  localparam logic [UW-1:0] TH_U  = UW'(RD_TH);
  localparam logic [UW-1:0] URG_U = UW'(RD_URG);

  state_t        state, state_nxt;
  bank_t         wr_bank, rd_bank, free_bank, full_sel;
  logic [OW-1:0] wr_off, rd_off;
  logic          last_wr, cam_pend, rd_pend, clr_q;
  logic          wr_full, wr_need, rd_need, gnt_rd, gnt_wr, grant, cam_go, rd_go, done_evt, frame_done;

  assign wr_full    = wr_off == FW_O;
  assign wr_need    = wrfifo_usedw >= BL_U && wr_off < FW_O;
  assign rd_need    = frame_ready && !rdfifo_clr && rdfifo_usedw <= TH_U && rd_off < FW_O;
  // frame switches wait for any burst of the same direction to finish
  assign cam_go     = (cam_frame_start || cam_pend) && !(state != IDLE && sd_wr);
  assign rd_go      = ((rdfifo_clr && !clr_q) || rd_pend) && !(state != IDLE && !sd_wr);
  assign frame_done = cam_go && wr_full;
  assign gnt_rd     = rd_need && (rdfifo_usedw < URG_U || !wr_need || last_wr);
  assign gnt_wr     = wr_need && !gnt_rd;
  // no grant while a bank/offset switch lands, so the issued address always matches the counter it advances
  assign grant      = state == IDLE && !cam_go && !rd_go && (gnt_rd || gnt_wr);
  assign done_evt   = (state == REQ && sd_ack && sd_done) || (state == BUSY && sd_done);

  fb_bank_sel u_bank_sel (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_bank  (wr_bank),
    .rd_bank  (rd_bank),
    .load     (frame_done),
    .free_bank(free_bank),
    .full_sel (full_sel)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb
    state_nxt = state == IDLE ? (grant ? REQ : IDLE) :
                state == REQ  ? (sd_ack ? (sd_done ? IDLE : BUSY) : REQ) :
                                (sd_done ? IDLE : BUSY);

  always_comb sd_req = state == REQ;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sd_wr       <= 1'b0;
      sd_addr     <= '0;
      frame_ready <= 1'b0;
      wr_overrun  <= 1'b0;
      wr_bank     <= BANK0;
      rd_bank     <= BANK2;
      wr_off      <= '0;
      rd_off      <= '0;
      last_wr     <= 1'b0;
      cam_pend    <= 1'b0;
      rd_pend     <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      clr_q    <= rdfifo_clr;
      cam_pend <= (cam_frame_start || cam_pend) && !cam_go;
      rd_pend  <= ((rdfifo_clr && !clr_q) || rd_pend) && !rd_go;
      if (grant) begin
        sd_wr   <= gnt_wr;
        sd_addr <= gnt_wr ? {wr_bank, wr_off} : {rd_bank, rd_off};
        last_wr <= gnt_wr;
      end
      if (done_evt && sd_wr) wr_off <= wr_off + BL_O;
      if (done_evt && !sd_wr) rd_off <= rd_off + BL_O;
      if (cam_go) begin
        wr_off     <= '0;
        wr_overrun <= 1'b0;
      end else if (wr_full && wrfifo_usedw >= BL_U) wr_overrun <= 1'b1;
      if (frame_done) begin
        frame_ready <= 1'b1;
        wr_bank     <= free_bank;
      end
      if (rd_go) begin
        rd_off  <= '0;
        rd_bank <= full_sel;
      end
    end
endmodule

// File: tb/tb_frame_buf_arbiter.sv
// tb_frame_buf_arbiter: scoreboard bench for frame_buf_arbiter with a small frame (32 words, 8-word bursts)
module tb_frame_buf_arbiter;
  localparam int BL = 8;
  localparam int FW = 32;
  localparam int AW = 22;
  localparam int UW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [UW-1:0] wrfifo_usedw = '0;
  logic [UW-1:0] rdfifo_usedw = '0;
  logic          cam_frame_start = 1'b0;
  logic          rdfifo_clr = 1'b0;
  logic          sd_ack = 1'b0;
  logic          sd_done = 1'b0;
  logic          sd_req, sd_wr, frame_ready, wr_overrun;
  logic [AW-1:0] sd_addr;

  int tests = 0;
  int fails = 0;
  logic [AW:0] exp_q[$];

  frame_buf_arbiter #(
    .BURST_LEN(BL), .FRAME_WORDS(FW), .ADDR_W(AW), .UW(UW), .RD_TH(256), .RD_URG(64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wrfifo_usedw   (wrfifo_usedw),
    .rdfifo_usedw   (rdfifo_usedw),
    .cam_frame_start(cam_frame_start),
    .rdfifo_clr     (rdfifo_clr),
    .sd_req         (sd_req),
    .sd_wr          (sd_wr),
    .sd_addr        (sd_addr),
    .sd_ack         (sd_ack),
    .sd_done        (sd_done),
    .frame_ready    (frame_ready),
    .wr_overrun     (wr_overrun)
  );

  always #5 clk = ~clk;

  task automatic push(input bit wr, input logic [1:0] bank, input int off);
    exp_q.push_back({wr, bank, (AW-2)'(off)});
  endtask

  task automatic pulse_cam();
    cam_frame_start = 1'b1;
    @(negedge clk);
    cam_frame_start = 1'b0;
  endtask

  // waits for a request, checks it against the scoreboard, then acts as the SDRAM controller
  task automatic do_burst(input string name, input bit same_done = 1'b0, input bit mid_cam = 1'b0);
    int n = 0;
    logic [AW:0] e = '1;
    while (!sd_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) e = exp_q.pop_front();
    tests++;
    if (!sd_req) begin
      fails++;
      $display("FAIL %s: no sd_req within 50 cycles, required wr=%0b addr=%h", name, e[AW], e[AW-1:0]);
      return;
    end
    if ({sd_wr, sd_addr} !== e) begin
      fails++;
      $display("FAIL %s: got wr=%0b addr=%h, required wr=%0b addr=%h", name, sd_wr, sd_addr, e[AW], e[AW-1:0]);
    end
    sd_ack = 1'b1;
    sd_done = same_done;
    @(negedge clk);
    sd_ack = 1'b0;
    sd_done = 1'b0;
    tests++;
    if (sd_req !== 1'b0) begin
      fails++;
      $display("FAIL %s_req_drop: sd_req=%0b after ack, required 0", name, sd_req);
    end
    if (!same_done) begin
      if (mid_cam) pulse_cam();
      repeat (2) @(negedge clk);
      sd_done = 1'b1;
      @(negedge clk);
      sd_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({sd_req, sd_wr, sd_addr, frame_ready, wr_overrun} !== '0) begin
      fails++;
      $display("FAIL reset: req=%0b wr=%0b addr=%h ready=%0b ovr=%0b, required all 0", sd_req, sd_wr, sd_addr, frame_ready, wr_overrun);
    end
  endtask

  task automatic test_write_basic();
    wrfifo_usedw = 9'd8;
    rdfifo_usedw = 9'd0;
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 2'd0, i * BL);
      do_burst($sformatf("wr_basic%0d", i));
    end
    wrfifo_usedw = 9'd0;
    @(negedge clk);
    tests++;
    if ({frame_ready, wr_overrun} !== 2'b00) begin
      fails++;
      $display("FAIL wr_basic_flags: ready=%0b ovr=%0b, required 0 0", frame_ready, wr_overrun);
    end
  endtask

  task automatic test_frame_swap();
    rdfifo_usedw = 9'd300;
    pulse_cam();
    tests++;
    if (frame_ready !== 1'b1) begin
      fails++;
      $display("FAIL frame_ready: got %0b, required 1", frame_ready);
    end
    rdfifo_clr = 1'b1;
    repeat (2) @(negedge clk);
    rdfifo_usedw = 9'd10;
    rdfifo_clr = 1'b0;
    push(1'b0, 2'd0, 0);
    do_burst("rd_after_clr");
  endtask

  task automatic test_arbitration();
    wrfifo_usedw = 9'd8;
    push(1'b0, 2'd0, 8);
    push(1'b0, 2'd0, 16);
    do_burst("urgent_rd0");
    do_burst("urgent_rd1");
    rdfifo_usedw = 9'd100;
    push(1'b1, 2'd1, 0);
    push(1'b0, 2'd0, 24);
    push(1'b1, 2'd1, 8);
    do_burst("alt_w0");
    do_burst("alt_r0");
    do_burst("alt_w1");
    wrfifo_usedw = 9'd0;
    rdfifo_usedw = 9'd300;
  endtask

  task automatic test_partial_frame();
    pulse_cam();
    wrfifo_usedw = 9'd8;
    push(1'b1, 2'd1, 0);
    do_burst("partial_restart");
    push(1'b1, 2'd1, 8);
    do_burst("cam_in_busy", 1'b0, 1'b1);
    push(1'b1, 2'd1, 0);
    do_burst("deferred_restart");
    wrfifo_usedw = 9'd0;
  endtask

  task automatic test_overrun();
    wrfifo_usedw = 9'd8;
    push(1'b1, 2'd1, 8);
    do_burst("ack_done_same", 1'b1);
    push(1'b1, 2'd1, 16);
    do_burst("after_same");
    push(1'b1, 2'd1, 24);
    do_burst("fill_last");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (sd_req !== 1'b0) begin
        fails++;
        $display("FAIL overrun_noreq: sd_req=%0b at cycle %0d, required 0", sd_req, i);
      end
    end
    tests++;
    if (wr_overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: got %0b, required 1", wr_overrun);
    end
    pulse_cam();
    tests++;
    if (wr_overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_clear: got %0b, required 0", wr_overrun);
    end
    push(1'b1, 2'd2, 0);
    do_burst("bank2_first");
    wrfifo_usedw = 9'd0;
  endtask

  task automatic test_simultaneous();
    wrfifo_usedw = 9'd8;
    for (int i = 1; i < 4; i++) begin
      push(1'b1, 2'd2, i * BL);
      do_burst($sformatf("bank2_fill%0d", i));
    end
    wrfifo_usedw = 9'd0;
    rdfifo_clr = 1'b1;
    pulse_cam();
    repeat (2) @(negedge clk);
    rdfifo_usedw = 9'd10;
    rdfifo_clr = 1'b0;
    push(1'b0, 2'd2, 0);
    do_burst("sim_reader_new_bank");
    rdfifo_usedw = 9'd300;
    wrfifo_usedw = 9'd8;
    push(1'b1, 2'd1, 0);
    do_burst("sim_writer_free_bank");
    wrfifo_usedw = 9'd0;
  endtask

  task automatic test_reset_busy();
    int n = 0;
    logic [AW:0] e = '1;
    wrfifo_usedw = 9'd8;
    push(1'b1, 2'd1, 8);
    while (!sd_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) e = exp_q.pop_front();
    tests++;
    if ({sd_req, sd_wr, sd_addr} !== {1'b1, e}) begin
      fails++;
      $display("FAIL busy_req: req=%0b wr=%0b addr=%h, required req=1 wr=%0b addr=%h", sd_req, sd_wr, sd_addr, e[AW], e[AW-1:0]);
    end
    sd_ack = 1'b1;
    @(negedge clk);
    sd_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({sd_req, sd_wr, sd_addr, frame_ready, wr_overrun} !== '0) begin
      fails++;
      $display("FAIL reset_in_busy: req=%0b wr=%0b addr=%h ready=%0b ovr=%0b, required all 0", sd_req, sd_wr, sd_addr, frame_ready, wr_overrun);
    end
    wrfifo_usedw = 9'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_frame_swap();
    test_arbitration();
    test_partial_frame();
    test_overrun();
    test_simultaneous();
    test_reset_busy();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
